// File: rtl/cbuf_write_arbiter.sv
// Round-robin write arbiter for one shared circular buffer: space check, push,
// atomic beat transfer, pop. Only this block writes the buffer, so free space never shrinks under it.
module cbuf_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 256,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    i_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_data,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic [NUM_REQ-1:0]              o_ack,
  output logic                            o_done,
  output logic                            o_buf_write_en,
  output logic [DATA_WIDTH-1:0]           o_buf_data,
  output logic                            o_buf_push_write_index,
  output logic                            o_buf_pop_write_index,
  input  logic [15:0]                     i_buf_data_size,
  input  logic                            i_buf_overrun,
  output logic [1:0]                      o_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PUSH, S_XFER, S_POP} state_t;

  state_t                               r_state, w_next;
  logic [IDX_W-1:0]                     r_owner, r_rr_ptr, w_pick, w_rr_next;
  logic [LEN_WIDTH-1:0]                 r_cnt;
  logic [1:0]                           r_error;
  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    w_len;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   w_data;
  logic [NUM_REQ-1:0]                   w_zero, w_valid, w_owner_oh;
  logic                                 w_found, w_fits;
  logic [16:0]                          w_free;

  assign w_len  = i_len;
  assign w_data = i_data;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign w_zero[k]  = i_req[k] && (w_len[k] == '0);
    assign w_valid[k] = i_req[k] && (w_len[k] != '0);
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && w_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  assign w_rr_next  = (w_pick == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  assign w_free     = 17'(BUFFER_SIZE - 1) - {1'b0, i_buf_data_size};
  assign w_fits     = 17'(r_cnt) <= w_free;
  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_CHECK;
      S_CHECK: if (w_fits)  w_next = S_PUSH;
      S_PUSH:  w_next = S_XFER;
      S_XFER:  if (i_buf_overrun || r_cnt <= LEN_WIDTH'(1)) w_next = S_POP;
      S_POP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_grant                = '0;
    o_ack                  = '0;
    o_done                 = 1'b0;
    o_buf_write_en         = 1'b0;
    o_buf_data             = '0;
    o_buf_push_write_index = 1'b0;
    o_buf_pop_write_index  = 1'b0;
    case (r_state)
      S_CHECK: o_grant = w_owner_oh;
      S_PUSH: begin
        o_grant                = w_owner_oh;
        o_buf_push_write_index = 1'b1;
      end
      S_XFER: begin
        o_grant        = w_owner_oh;
        o_ack          = w_owner_oh;
        o_buf_write_en = 1'b1;
        o_buf_data     = w_data[r_owner];
      end
      S_POP: begin
        o_grant               = w_owner_oh;
        o_buf_pop_write_index = 1'b1;
        o_done                = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_error  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (|w_zero) r_error[0] <= 1'b1;
        if (w_found) begin
          r_owner  <= w_pick;
          r_cnt    <= w_len[w_pick];
          r_rr_ptr <= w_rr_next;
        end
      end
      if (r_state == S_XFER) begin
        r_cnt <= r_cnt - 1'b1;
        if (i_buf_overrun) r_error[1] <= 1'b1;
      end
    end
  end

  assign o_error = r_error;

endmodule

// File: tb/tb_cbuf_write_arbiter.sv
// Directed bench for cbuf_write_arbiter with a tiny buffer-occupancy model and per-producer data counters.
module tb_cbuf_write_arbiter;
  localparam int NR = 4, DW = 8, LW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*LW-1:0]  len;
  logic [NR*DW-1:0]  data;
  logic [NR-1:0]     grant, ack;
  logic              done, wen, push, pop, ovr;
  logic [DW-1:0]     bdata;
  logic [15:0]       bsize16;
  logic [1:0]        err;

  int bsize;
  logic sz_load, drain;
  int   sz_val;
  int   dptr [NR];
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  cbuf_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUFFER_SIZE(256), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_len(len), .i_data(data),
    .o_grant(grant), .o_ack(ack), .o_done(done), .o_buf_write_en(wen), .o_buf_data(bdata),
    .o_buf_push_write_index(push), .o_buf_pop_write_index(pop),
    .i_buf_data_size(bsize16), .i_buf_overrun(ovr), .o_error(err));

  // Buffer occupancy as seen at the falling edge.
  always @(negedge clk) begin
    if (sz_load) bsize <= sz_val;
    else         bsize <= bsize + (wen ? 1 : 0) - (drain ? 1 : 0);
  end
  assign bsize16 = 16'(bsize);

  // Producers advance data after each ack; restart on done or reset.
  always @(posedge clk) begin
    for (int k = 0; k < NR; k++) begin
      if (rst || (done && grant[k])) dptr[k] <= 0;
      else if (ack[k])               dptr[k] <= dptr[k] + 1;
    end
  end
  always_comb begin
    data = '0;
    for (int k = 0; k < NR; k++) data[k*DW +: DW] = 8'(k*16 + dptr[k]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_len(input int k, input int v);
    len[k*LW +: LW] = 8'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ovr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load_size(input int v);
    sz_val = v; sz_load = 1'b1;
    tick();
    sz_load = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ".outs"}, {grant, ack, 4'(done), 4'(wen), 4'(push), 4'(pop), 8'(bdata)},
        32'h0);
  endtask

  initial begin
    rst = 1'b1; req = '0; len = '0; ovr = 1'b0; sz_load = 1'b0; drain = 1'b0; sz_val = 0;
    bsize = 0;
    do_reset();
    chk_outs_zero("reset");
    chk("reset.err", 32'(err), 0);

    // single packet, producer 0, len 3
    load_size(0);
    set_len(0, 3); req = 4'b0001;
    tick(); chk("p1.check_grant", 32'(grant), 1); chk("p1.no_push", 32'(push), 0);
    tick(); chk("p1.push", {31'(grant), push}, {31'd1, 1'b1});
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("p1.beat", {8'(ack), 8'(wen), 8'(push|pop), bdata}, {8'h1, 8'h1, 8'h0, 8'(b)});
    end
    tick(); chk("p1.pop", {4'(pop), 4'(done), 4'(wen), 4'(push)}, {4'd1, 4'd1, 4'd0, 4'd0});
    req = '0;
    tick(); chk_outs_zero("p1.idle"); chk("p1.size", bsize, 3);

    // round robin, all four held, len 2
    do_reset(); load_size(0);
    for (int k = 0; k < NR; k++) set_len(k, 2);
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      tick(); chk("rr.grant", 32'(grant), 32'(1 << (p % NR)));
      tick(); chk("rr.push", 32'(push), 1);
      tick(); chk("rr.ack0", 32'(ack), 32'(1 << (p % NR)));
      chk("rr.data0", 32'(bdata), 32'((p % NR) * 16));
      tick(); chk("rr.ack1", 32'(ack), 32'(1 << (p % NR)));
      chk("rr.data1", 32'(bdata), 32'((p % NR) * 16 + 1));
      tick(); chk("rr.done", {31'(grant), done}, {31'(1 << (p % NR)), 1'b1});
      tick(); chk("rr.idle", 32'(grant), 0);
    end
    req = '0;
    chk("rr.size", bsize, 10);

    // space wait: 253 full, need 4, drain 2
    load_size(253);
    set_len(1, 4); req = 4'b0010;
    tick(); chk("sw.grant", 32'(grant), 32'b0010);
    tick(); tick();
    chk("sw.hold", {31'(grant), push}, {31'b0010, 1'b0});
    drain = 1'b1;
    tick(); chk("sw.hold2", 32'(push), 0);
    tick(); chk("sw.push", 32'(push), 1);
    drain = 1'b0;
    for (int b = 0; b < 4; b++) begin tick(); chk("sw.wen", 32'(wen), 1); end
    tick(); chk("sw.pop", 32'(pop), 1);
    req = '0;
    tick(); chk("sw.size", bsize, 255); chk("sw.err", 32'(err), 0);

    // zero length requester skipped
    do_reset(); load_size(0);
    set_len(0, 0); set_len(1, 5); req = 4'b0011;
    tick(); chk("zl.grant", 32'(grant), 32'b0010); chk("zl.err", 32'(err), 1);
    tick();
    for (int b = 0; b < 5; b++) begin
      tick(); chk("zl.ack", 32'(ack), 32'b0010); chk("zl.data", 32'(bdata), 32'(16 + b));
    end
    tick(); chk("zl.pop", 32'(pop), 1);
    req = '0;
    tick(); chk("zl.idle_err", {30'(grant), err}, {30'd0, 2'b01});

    // overrun on second beat
    do_reset(); load_size(0);
    set_len(0, 4); req = 4'b0001;
    tick(); tick(); tick();
    chk("ov.beat0", 32'(wen), 1);
    tick(); chk("ov.beat1", 32'(wen), 1);
    ovr = 1'b1;
    tick(); ovr = 1'b0;
    chk("ov.pop", {4'(pop), 4'(wen), 4'(done)}, {4'd1, 4'd0, 4'd1});
    chk("ov.err", 32'(err), 2);
    req = '0;
    tick(); chk_outs_zero("ov.idle");

    // reset mid-transfer, then re-request checks rr_ptr back to 0
    load_size(0);
    set_len(0, 5); req = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("rs.beat1", {8'(ack), bdata}, {8'h1, 8'h1});
    rst = 1'b1;
    tick(); chk_outs_zero("rs.after"); chk("rs.err", 32'(err), 0);
    rst = 1'b0;
    set_len(0, 2); set_len(1, 2); req = 4'b0011;
    tick(); chk("rs.regrant", 32'(grant), 1);
    tick(); tick(); chk("rs.data", {8'(ack), bdata}, {8'h1, 8'h0});
    tick(); tick(); chk("rs.pop", 32'(pop), 1);
    req = '0;
    tick(); chk_outs_zero("rs.idle");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end
endmodule
